// File: rtl/fifo_op_sched_pkg.sv
// Shared constants for the three-FIFO single-bit operator scheduler:
// bus address map, operator encodings and controller states.
package fifo_op_sched_pkg;

    localparam logic [2:0] ADDR_A      = 3'd4;
    localparam logic [2:0] ADDR_B      = 3'd5;
    localparam logic [2:0] ADDR_RUN    = 3'd6;
    localparam logic [2:0] ADDR_CLR    = 3'd7;

    localparam logic [2:0] RD_A_FULLN  = 3'd0;
    localparam logic [2:0] RD_B_FULLN  = 3'd1;
    localparam logic [2:0] RD_Y_EMPTYN = 3'd2;
    localparam logic [2:0] RD_Y_DATA   = 3'd3;
    localparam logic [2:0] RD_RUN      = 3'd6;
    localparam logic [2:0] RD_ERR      = 3'd7;

    localparam logic [1:0] OP_OR       = 2'd0;
    localparam logic [1:0] OP_AND      = 2'd1;
    localparam logic [1:0] OP_XOR      = 2'd2;
    localparam logic [1:0] OP_RSVD     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_op_sched.sv
// Bus-facing sequencer for the A/B operand FIFOs and Y result FIFO.
//   state    | meaning
//   ST_RUN   | operator fires whenever both operands and result space exist
//   ST_HALT  | bus traffic only, operator never fires
//   ST_CLEAR | fifo_clr held for CLR_CYCLES cycles, bus stalled, then RUN
module fifo_op_sched
    import fifo_op_sched_pkg::*;
#(
    parameter logic [1:0]  OP         = 2'd0,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] write_address,
    input  logic       write_data,
    input  logic       write_en,
    output logic       write_rdy,
    input  logic [2:0] read_address,
    input  logic       read_en,
    output logic       read_data,
    output logic       read_rdy,
    input  logic       a_full_n,
    input  logic       a_empty_n,
    input  logic       a_dout,
    input  logic       b_full_n,
    input  logic       b_empty_n,
    input  logic       b_dout,
    input  logic       y_full_n,
    input  logic       y_empty_n,
    input  logic       y_dout,
    output logic       a_enq,
    output logic       a_deq,
    output logic       a_din,
    output logic       b_enq,
    output logic       b_deq,
    output logic       b_din,
    output logic       y_enq,
    output logic       y_deq,
    output logic       y_din,
    output logic       fifo_clr
);

    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] clr_cnt_q, clr_cnt_d;
    logic       err_q, err_d;
    logic       in_clear, wr_acc, rd_acc, fire, op_res, rd_val;

    assign in_clear = (state_q == ST_CLEAR);

    always_comb begin
        write_rdy = 1'b0;
        if (!in_clear) begin
            case (write_address)
                ADDR_A:  write_rdy = a_full_n;
                ADDR_B:  write_rdy = b_full_n;
                default: write_rdy = 1'b1;
            endcase
        end
    end

    assign read_rdy = !in_clear;
    assign wr_acc   = write_en && write_rdy;
    assign rd_acc   = read_en && read_rdy;

    assign fire = (state_q == ST_RUN) && a_empty_n && b_empty_n && y_full_n;

    // Reserved encoding falls through to OR.
    always_comb begin
        case (OP)
            OP_AND:  op_res = a_dout & b_dout;
            OP_XOR:  op_res = a_dout ^ b_dout;
            default: op_res = a_dout | b_dout;
        endcase
    end

    assign a_enq    = wr_acc && (write_address == ADDR_A);
    assign b_enq    = wr_acc && (write_address == ADDR_B);
    assign a_din    = a_enq & write_data;
    assign b_din    = b_enq & write_data;
    assign a_deq    = fire;
    assign b_deq    = fire;
    assign y_enq    = fire;
    assign y_din    = fire & op_res;
    assign y_deq    = rd_acc && (read_address == RD_Y_DATA) && y_empty_n;
    assign fifo_clr = in_clear;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_RUN, ST_HALT: begin
                if (wr_acc && (write_address == ADDR_RUN)) begin
                    state_d = write_data ? ST_RUN : ST_HALT;
                end else if (wr_acc && (write_address == ADDR_CLR) && write_data) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == 4'd0) state_d = ST_RUN;
                else                   clr_cnt_d = clr_cnt_q - 4'd1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A set in the same cycle as a read-7 clear wins so no error is lost.
    always_comb begin
        err_d = err_q;
        if (in_clear) begin
            err_d = 1'b0;
        end else begin
            if (rd_acc && (read_address == RD_ERR)) err_d = 1'b0;
            if (wr_acc && (write_address < ADDR_A)) err_d = 1'b1;
            if (rd_acc && (read_address == RD_Y_DATA) && !y_empty_n) err_d = 1'b1;
        end
    end

    always_comb begin
        rd_val = 1'b0;
        case (read_address)
            RD_A_FULLN:  rd_val = a_full_n;
            RD_B_FULLN:  rd_val = b_full_n;
            RD_Y_EMPTYN: rd_val = y_empty_n;
            RD_Y_DATA:   rd_val = y_empty_n & y_dout;
            RD_RUN:      rd_val = (state_q == ST_RUN);
            RD_ERR:      rd_val = err_q;
            default:     rd_val = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_RUN;
            clr_cnt_q <= 4'd0;
            err_q     <= 1'b0;
            read_data <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
            if (rd_acc) read_data <= rd_val;
        end
    end

endmodule
